// File: rtl/rng_seed_ctrl.sv
// rng_seed_ctrl: seed-side initiator for the rng96 core.
// Assembles a 96-bit seed from three 32-bit host beats and strobes it into the core.
// Gates consumers through a warm-up window, then periodically reseeds the core
// from its own output XORed with the current seed.
module rng_seed_ctrl #(
   parameter int WARMUP        = 16,    // >= 1
   parameter int RESEED_PERIOD = 4096,  // 0 disables auto-reseed
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      seed_word,
   input  logic             seed_valid,
   output logic             seed_ready,
   input  logic [95:0]      random_in,
   output logic             loadseed,
   output logic [95:0]      seed_out,
   output logic             rng_ok,
   output logic             busy,
   output logic [CNT_W-1:0] reseed_cnt
);

   typedef enum logic [2:0] {IDLE, COLLECT, LOAD, WARM, RUN} state_t;

   localparam int WARM_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
   localparam int PER_W  = (RESEED_PERIOD > 1) ? $clog2(RESEED_PERIOD) : 1;
   localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP - 1);
   localparam logic [PER_W-1:0]  PER_LAST  = PER_W'((RESEED_PERIOD > 0) ? RESEED_PERIOD - 1 : 0);
   localparam logic              RESEED_EN = (RESEED_PERIOD != 0);

   state_t            state;
   logic [1:0]        beat_cnt;
   logic [31:0]       seed_hi;
   logic [31:0]       seed_mid;
   logic [WARM_W-1:0] warm_cnt;
   logic [PER_W-1:0]  period_cnt;
   logic              beat_acc;

   // An all-zero seed would lock the LFSR-type core, so substitute 1.
   function automatic logic [95:0] nz_seed(input logic [95:0] s);
      return (s == 96'h0) ? 96'h1 : s;
   endfunction

   // Handshake and status decode straight from the state register.
   assign seed_ready = (state == IDLE) || (state == COLLECT) || (state == RUN);
   assign busy       = (state == COLLECT) || (state == LOAD) || (state == WARM);
   assign rng_ok     = (state == RUN);
   assign beat_acc   = seed_valid && seed_ready;

   // Main control FSM: beat collection, load strobe, warm-up and periodic reseed.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         beat_cnt   <= 2'd0;
         seed_hi    <= 32'h0;
         seed_mid   <= 32'h0;
         warm_cnt   <= '0;
         period_cnt <= '0;
         loadseed   <= 1'b0;
         seed_out   <= 96'h0;
         reseed_cnt <= '0;
      end else begin
         loadseed <= 1'b0;
         case (state)
            IDLE: begin
               if (beat_acc) begin
                  seed_hi  <= seed_word;
                  beat_cnt <= 2'd1;
                  state    <= COLLECT;
               end
            end
            COLLECT: begin
               if (beat_acc) begin
                  if (beat_cnt == 2'd1) begin
                     seed_mid <= seed_word;
                     beat_cnt <= 2'd2;
                  end else begin
                     // Third beat: seed_out lands together with the strobe.
                     seed_out <= nz_seed({seed_hi, seed_mid, seed_word});
                     loadseed <= 1'b1;
                     beat_cnt <= 2'd0;
                     state    <= LOAD;
                  end
               end
            end
            LOAD: begin
               warm_cnt <= '0;
               state    <= WARM;
            end
            WARM: begin
               if (warm_cnt == WARM_LAST) begin
                  period_cnt <= '0;
                  state      <= RUN;
               end else begin
                  warm_cnt <= warm_cnt + 1'b1;
               end
            end
            RUN: begin
               if (beat_acc) begin
                  // Host beat wins over a coinciding period expiry.
                  seed_hi    <= seed_word;
                  beat_cnt   <= 2'd1;
                  period_cnt <= '0;
                  state      <= COLLECT;
               end else if (RESEED_EN && (period_cnt == PER_LAST)) begin
                  seed_out   <= nz_seed(random_in ^ seed_out);
                  loadseed   <= 1'b1;
                  period_cnt <= '0;
                  if (reseed_cnt != {CNT_W{1'b1}})
                     reseed_cnt <= reseed_cnt + 1'b1;
                  state      <= LOAD;
               end else if (RESEED_EN) begin
                  period_cnt <= period_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rng_seed_ctrl.sv
// Directed bench for rng_seed_ctrl with WARMUP=16 and RESEED_PERIOD=8.
module tb_rng_seed_ctrl;

   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [31:0]      seed_word = 32'h0;
   logic             seed_valid = 1'b0;
   logic             seed_ready;
   logic [95:0]      random_in = 96'hffffffff00000000ffffffff;
   logic             loadseed;
   logic [95:0]      seed_out;
   logic             rng_ok;
   logic             busy;
   logic [CNT_W-1:0] reseed_cnt;

   int errors = 0;
   int checks = 0;
   int ld_cnt = 0;
   int ld_base;
   int n;
   logic [CNT_W-1:0] rc_base;

   rng_seed_ctrl #(.WARMUP(16), .RESEED_PERIOD(8), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .seed_word(seed_word), .seed_valid(seed_valid), .seed_ready(seed_ready),
      .random_in(random_in), .loadseed(loadseed), .seed_out(seed_out),
      .rng_ok(rng_ok), .busy(busy), .reseed_cnt(reseed_cnt)
   );

   always #5 clk = ~clk;

   // Count load strobes mid-cycle.
   always @(negedge clk) if (loadseed) ld_cnt <= ld_cnt + 1;

   task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one clock; observe 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one beat, wait (bounded) for acceptance, then drop valid.
   task automatic send_beat(input logic [31:0] w);
      int i;
      seed_word  = w;
      seed_valid = 1'b1;
      for (i = 0; i < 100 && !seed_ready; i++) step();
      if (!seed_ready) chk("beat_timeout", 0, 1);
      step();
      seed_valid = 1'b0;
   endtask

   // Step until rng_ok rises; return cycles taken, checking busy during warm-up.
   task automatic wait_ok(output int cyc);
      logic busy_low;
      busy_low = 1'b0;
      cyc = 0;
      for (int i = 1; i <= 60; i++) begin
         step();
         if (rng_ok) begin cyc = i; break; end
         if (!busy) busy_low = 1'b1;
      end
      chk("busy_warm", busy_low, 0);
   endtask

   initial begin
      // Reset state
      step(); step();
      rst = 1'b0;
      chk("rst_loadseed", loadseed, 0);
      chk("rst_seed_out", seed_out, 0);
      chk("rst_rng_ok", rng_ok, 0);
      chk("rst_busy", busy, 0);
      chk("rst_reseed_cnt", reseed_cnt, 0);
      chk("rst_seed_ready", seed_ready, 1);

      // Basic load
      ld_base = ld_cnt;
      send_beat(32'hdeadbeef);
      chk("col_busy", busy, 1);
      send_beat(32'h12345678);
      send_beat(32'h90abcdef);
      chk("load_strobe", loadseed, 1);
      chk("load_seed", seed_out, 96'hdeadbeef1234567890abcdef);
      chk("load_ready", seed_ready, 0);
      wait_ok(n);
      chk("warm_len", n, 17);
      chk("load_pulses", ld_cnt - ld_base, 1);
      chk("run_busy", busy, 0);

      // Auto-reseed after 8 RUN cycles
      ld_base = ld_cnt;
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (loadseed) begin n = i; break; end
      end
      chk("reseed_delay", n, 8);
      chk("reseed_seed", seed_out, 96'h21524110123456786f543210);
      chk("reseed_cnt1", reseed_cnt, 1);
      chk("reseed_ok", rng_ok, 0);
      wait_ok(n);
      chk("reseed_warm", n, 17);

      // Zero seed guard
      ld_base = ld_cnt;
      send_beat(32'h0);
      send_beat(32'h0);
      send_beat(32'h0);
      chk("zero_strobe", loadseed, 1);
      chk("zero_seed", seed_out, 96'h1);

      // Backpressure: beat held through warm-up, accepted on first RUN cycle
      seed_word  = 32'h11111111;
      seed_valid = 1'b1;
      step();
      chk("bp_ready", seed_ready, 0);
      chk("bp_busy", busy, 1);
      wait_ok(n);
      chk("bp_warm", n, 16);
      chk("zero_pulses", ld_cnt - ld_base, 1);
      ld_base = ld_cnt;
      step();
      seed_valid = 1'b0;
      chk("bp_collect_ok", rng_ok, 0);
      chk("bp_collect_busy", busy, 1);
      chk("bp_collect_ready", seed_ready, 1);
      send_beat(32'h22222222);
      send_beat(32'h33333333);
      chk("bp_seed", seed_out, 96'h111111112222222233333333);
      wait_ok(n);
      chk("bp_pulses", ld_cnt - ld_base, 1);

      // Collision: beat0 on the period-expiry cycle
      rc_base = reseed_cnt;
      ld_base = ld_cnt;
      for (int i = 0; i < 7; i++) step();
      chk("col_pre_ok", rng_ok, 1);
      seed_word  = 32'haaaaaaaa;
      seed_valid = 1'b1;
      step();
      seed_valid = 1'b0;
      chk("col_no_load", loadseed, 0);
      chk("col_cnt", reseed_cnt, rc_base);
      chk("col_state_busy", busy, 1);
      chk("col_state_ready", seed_ready, 1);
      chk("col_state_ok", rng_ok, 0);
      chk("col_pulses", ld_cnt - ld_base, 0);

      // Reset mid-collect after two beats
      send_beat(32'hbbbbbbbb);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mrst_seed", seed_out, 0);
      chk("mrst_cnt", reseed_cnt, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_load", loadseed, 0);
      ld_base = ld_cnt;
      send_beat(32'h00000001);
      send_beat(32'h00000002);
      send_beat(32'h00000003);
      chk("mrst_strobe", loadseed, 1);
      chk("mrst_seed2", seed_out, 96'h000000010000000200000003);
      wait_ok(n);
      chk("mrst_pulses", ld_cnt - ld_base, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
